// File: rtl/odve_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : odve_uart_rx
// Brief    : UART receiver with a 2-flop input synchroniser, mid-bit sampling
//            (LSB first), stop-bit check and a valid/ready output register.
//            Parity stage is compiled in by defining ODVE_UART_RX_PARITY_EN.
// Revision : 1.0  initial release
// ============================================================================
module odve_uart_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] C_CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] C_CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);
  localparam logic [IDX_W-1:0] C_IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] C_LAST_BIT = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [1:0]            r_sync;
  logic                  w_rxd_s;
  logic [CNT_W-1:0]      r_cnt;
  logic [IDX_W-1:0]      r_bit_idx;
  logic [DATA_BITS-1:0]  r_shift;
  logic                  w_sample;
  logic                  w_complete;
  logic                  w_load;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sync <= 2'b11;
    else     r_sync <= {r_sync[0], rxd};
  end

  assign w_rxd_s = r_sync[1];
  assign w_sample = (r_cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_complete  = 1'b0;
    case (r_state)
      S_IDLE:  if (!w_rxd_s) w_state_nxt = S_START;
      S_START: if (w_sample) w_state_nxt = w_rxd_s ? S_IDLE : S_DATA;
      S_DATA: begin
        if (w_sample && (r_bit_idx == C_LAST_BIT)) begin
`ifdef ODVE_UART_RX_PARITY_EN
          w_state_nxt = S_PARITY;
`else
          w_state_nxt = S_STOP;
`endif
        end
      end
`ifdef ODVE_UART_RX_PARITY_EN
      S_PARITY: if (w_sample) w_state_nxt = S_STOP;
`endif
      S_STOP: begin
        if (w_sample) begin
          w_complete  = 1'b1;
          w_state_nxt = w_rxd_s ? S_IDLE : S_BREAK;
        end
      end
      // A held-low line must go high before a new start bit is accepted.
      S_BREAK: if (w_rxd_s) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // IDLE keeps the counter primed with the half-bit offset to land mid-bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      if (r_state == S_IDLE) begin
        r_cnt     <= C_CNT_HALF;
        r_bit_idx <= '0;
      end else if (w_sample) begin
        r_cnt <= C_CNT_FULL;
      end else begin
        r_cnt <= r_cnt - C_CNT_ONE;
      end
      if ((r_state == S_DATA) && w_sample) begin
        r_shift   <= {w_rxd_s, r_shift[DATA_BITS-1:1]};
        r_bit_idx <= r_bit_idx + C_IDX_ONE;
      end
    end
  end

  // A completed byte only loads if the slot is free or being emptied now.
  assign w_load = w_complete && !(rx_valid && !rx_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (w_load) begin
        rx_data   <= r_shift;
        frame_err <= ~w_rxd_s;
        rx_valid  <= 1'b1;
      end else if (w_complete) begin
        overrun <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

`ifdef ODVE_UART_RX_PARITY_EN
  logic r_par_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_par_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if ((r_state == S_PARITY) && w_sample)
        r_par_err <= w_rxd_s ^ (^r_shift) ^ PARITY_ODD;
      if (w_load)
        parity_err <= r_par_err;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

  assign busy = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_odve_uart_rx.sv
`default_nettype none
// Bench for odve_uart_rx: frame-level timing model scored every cycle, plus
// directed frames with literal expectations and a randomized frame stream.
module tb_odve_uart_rx;

  localparam int C  = 16;
  localparam int DB = 8;
  localparam bit PO = 1'b0;
`ifdef ODVE_UART_RX_PARITY_EN
  localparam int NB = DB + 1;
`else
  localparam int NB = DB;
`endif
  // Edges from the start-bit drive to the output load: sync (2) + detect (1)
  // + half bit + full bits up to the stop-bit midpoint.
  localparam int LAT = 3 + C / 2 + C * (NB + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          rxd;
  logic          rx_ready;
  logic [DB-1:0] rx_data;
  logic          rx_valid;
  logic          frame_err;
  logic          parity_err;
  logic          overrun;
  logic          busy;

  odve_uart_rx #(
    .CLKS_PER_BIT (C),
    .DATA_BITS    (DB),
    .PARITY_ODD   (PO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rxd        (rxd),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int n_sent = 0;
  int n_done = 0;
  int            fr_cycle [512];
  logic [DB-1:0] fr_data  [512];
  logic          fr_ferr  [512];
  logic          fr_perr  [512];

  logic          m_valid = 1'b0;
  logic [DB-1:0] m_data = '0;
  logic          m_ferr = 1'b0;
  logic          m_perr = 1'b0;
  logic          m_ovr = 1'b0;
  int            m_hs = 0;

  int            hs_cnt = 0;
  int            ovr_cnt = 0;
  logic [DB-1:0] last_data = '0;
  logic          last_ferr = 1'b0;
  logic          last_perr = 1'b0;
  int            ready_mode = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic good_par(input logic [DB-1:0] d);
    return (^d) ^ PO;
  endfunction

  // Tasks are entered one time unit after a rising edge.
  task automatic drive_bit(input logic b, input int n);
    rxd = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    drive_bit(1'b1, n);
  endtask

  task automatic send_frame(input logic [DB-1:0] d, input logic stop, input logic par);
    fr_cycle[n_sent] = cyc + LAT;
    fr_data[n_sent]  = d;
    fr_ferr[n_sent]  = ~stop;
`ifdef ODVE_UART_RX_PARITY_EN
    fr_perr[n_sent]  = par ^ (^d) ^ PO;
`else
    fr_perr[n_sent]  = 1'b0 & par;
`endif
    n_sent++;
    drive_bit(1'b0, C);
    for (int i = 0; i < DB; i++) drive_bit(d[i], C);
`ifdef ODVE_UART_RX_PARITY_EN
    drive_bit(par, C);
`endif
    drive_bit(stop, C);
  endtask

  int hs0;
  int ov0;
  logic [DB-1:0] rd;
  logic rbad;

  initial begin
    rst = 1'b1;
    rxd = 1'b1;
    rx_ready = 1'b0;

    fork
      // Frame-level model: each announced frame completes at its computed edge.
      forever begin
        logic hs;
        @(posedge clk);
        cyc++;
        if (rst) begin
          m_valid = 1'b0; m_data = '0; m_ferr = 1'b0; m_perr = 1'b0; m_ovr = 1'b0;
          n_done = n_sent;
        end else begin
          m_ovr = 1'b0;
          hs = m_valid && rx_ready;
          if (hs) m_hs++;
          if ((n_done < n_sent) && (fr_cycle[n_done] == cyc)) begin
            if (m_valid && !rx_ready) begin
              m_ovr = 1'b1;
            end else begin
              m_valid = 1'b1;
              m_data  = fr_data[n_done];
              m_ferr  = fr_ferr[n_done];
              m_perr  = fr_perr[n_done];
            end
            n_done++;
          end else if (hs) begin
            m_valid = 1'b0;
          end
        end
      end
      forever begin
        @(negedge clk);
        if (!rst) begin
          check("rx_valid", {31'd0, rx_valid}, {31'd0, m_valid});
          if (m_valid) begin
            check("rx_data", {24'd0, rx_data}, {24'd0, m_data});
            check("frame_err", {31'd0, frame_err}, {31'd0, m_ferr});
            check("parity_err", {31'd0, parity_err}, {31'd0, m_perr});
          end
          check("overrun", {31'd0, overrun}, {31'd0, m_ovr});
          if (rx_valid && rx_ready) begin
            hs_cnt++;
            last_data = rx_data;
            last_ferr = frame_err;
            last_perr = parity_err;
          end
          if (overrun) ovr_cnt++;
        end
      end
      forever begin
        @(posedge clk);
        #1;
        case (ready_mode)
          0:       rx_ready = 1'b0;
          1:       rx_ready = 1'b1;
          default: rx_ready = ($urandom_range(0, 3) != 0);
        endcase
      end
      begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
      end
    join_none

    repeat (4) @(posedge clk);
    #1;
    check("reset rx_valid", {31'd0, rx_valid}, 32'd0);
    check("reset rx_data", {24'd0, rx_data}, 32'd0);
    check("reset frame_err", {31'd0, frame_err}, 32'd0);
    check("reset overrun", {31'd0, overrun}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    ready_mode = 1;
    idle(8);

    // 0xA5 on the wire: 0,1,0,1,0,0,1,0,1,1
    hs0 = hs_cnt;
    send_frame(8'hA5, 1'b1, good_par(8'hA5));
    idle(4);
    check("a5 handshakes", hs_cnt - hs0, 32'd1);
    check("a5 data", {24'd0, last_data}, 32'h0000_00A5);
    check("a5 frame_err", {31'd0, last_ferr}, 32'd0);
    check("a5 busy after", {31'd0, busy}, 32'd0);

    // 4-cycle glitch is rejected by the start-bit check.
    hs0 = hs_cnt;
    drive_bit(1'b0, 4);
    rxd = 1'b1;
    check("glitch busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 8 && busy; i++) begin
      @(posedge clk);
      #1;
    end
    check("glitch busy clears", {31'd0, busy}, 32'd0);
    idle(8);
    check("glitch no byte", hs_cnt - hs0, 32'd0);

    // Bad stop bit followed by a 40-cycle break.
    hs0 = hs_cnt;
    send_frame(8'h3C, 1'b0, good_par(8'h3C));
    drive_bit(1'b0, 40);
    check("break handshakes", hs_cnt - hs0, 32'd1);
    check("break data", {24'd0, last_data}, 32'h0000_003C);
    check("break frame_err", {31'd0, last_ferr}, 32'd1);
    check("break busy", {31'd0, busy}, 32'd1);
    idle(8);
    check("break busy clears", {31'd0, busy}, 32'd0);
    check("break single byte", hs_cnt - hs0, 32'd1);

    // Back-to-back frames with the consumer stalled.
    ready_mode = 0;
    idle(3);
    hs0 = hs_cnt;
    ov0 = ovr_cnt;
    send_frame(8'h11, 1'b1, good_par(8'h11));
    send_frame(8'h22, 1'b1, good_par(8'h22));
    idle(4);
    check("ovr rx_valid held", {31'd0, rx_valid}, 32'd1);
    check("ovr data kept", {24'd0, rx_data}, 32'h0000_0011);
    check("ovr pulses", ovr_cnt - ov0, 32'd1);
    ready_mode = 1;
    idle(3);
    check("ovr rx_valid falls", {31'd0, rx_valid}, 32'd0);
    check("ovr handshakes", hs_cnt - hs0, 32'd1);
    check("ovr accepted data", {24'd0, last_data}, 32'h0000_0011);

`ifdef ODVE_UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0);
    idle(4);
    check("parity bad", {31'd0, last_perr}, 32'd1);
    send_frame(8'h07, 1'b1, 1'b1);
    idle(4);
    check("parity good", {31'd0, last_perr}, 32'd0);
`endif

    // Reset in the middle of data bit 3 of 0xFF.
    drive_bit(1'b0, C);
    for (int i = 0; i < 3; i++) drive_bit(1'b1, C);
    drive_bit(1'b1, C / 2);
    check("pre-reset busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("midrst rx_valid", {31'd0, rx_valid}, 32'd0);
    check("midrst rx_data", {24'd0, rx_data}, 32'd0);
    check("midrst frame_err", {31'd0, frame_err}, 32'd0);
    check("midrst parity_err", {31'd0, parity_err}, 32'd0);
    check("midrst overrun", {31'd0, overrun}, 32'd0);
    check("midrst busy", {31'd0, busy}, 32'd0);
    rxd = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(4);
    hs0 = hs_cnt;
    send_frame(8'h5A, 1'b1, good_par(8'h5A));
    idle(4);
    check("post-reset handshakes", hs_cnt - hs0, 32'd1);
    check("post-reset data", {24'd0, last_data}, 32'h0000_005A);
    check("post-reset frame_err", {31'd0, last_ferr}, 32'd0);

    // Random frames, gaps, bad stops and consumer back-pressure.
    ready_mode = 2;
    for (int n = 0; n < 40; n++) begin
      rd   = DB'($urandom);
      rbad = ($urandom_range(0, 5) == 0);
      send_frame(rd, ~rbad, 1'($urandom));
      if (rbad) begin
        drive_bit(1'b0, $urandom_range(0, 20));
        idle($urandom_range(4, 12));
      end else begin
        idle($urandom_range(0, 12));
      end
    end
    ready_mode = 1;
    idle(6);
    check("drain rx_valid", {31'd0, rx_valid}, 32'd0);
    check("total handshakes", hs_cnt, m_hs);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
